fpu_result_queue: RTL and testbench

//   Downstream stage of the combinational single-precision add/sub datapath. Captures each
//   32-bit result with its overflow/underflow flags into a small FIFO and presents it on a

---
 rtl/fpu_result_queue.sv | 147 ++++++++++++++
 tb/tb_fpu_result_queue.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fpu_result_queue.sv
// Result FIFO behind the single-precision add/sub datapath, with sticky exception status.
// Optional saturating overflow/underflow event counters enabled by defining FPU_RQ_EVENT_CNT_EN.
module fpu_result_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [31:0]             i_32_s,
    input  logic                    i_ov_flag,
    input  logic                    i_un_flag,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [31:0]             o_32_s,
    output logic                    o_ov_flag,
    output logic                    o_un_flag,
    input  logic                    i_flush,
    input  logic                    i_sticky_clr,
    output logic                    o_sticky_ov,
    output logic                    o_sticky_un,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic [CNT_W-1:0]        o_ov_cnt,
    output logic [CNT_W-1:0]        o_un_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [33:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [33:0]   head_q, head_d;
    logic          sticky_ov_q, sticky_ov_d;
    logic          sticky_un_q, sticky_un_d;
    logic [33:0]   din;
    logic          full, empty, push, pop;

    assign din = {i_ov_flag, i_un_flag, i_32_s};

    always_comb begin
        full    = (count_q == CW'(DEPTH));
        empty   = (count_q == '0);
        o_ready = ~full & ~i_flush;
        o_valid = ~empty;
        push    = i_valid & o_ready;
        pop     = o_valid & i_ready & ~i_flush;
    end

    // head_q mirrors the entry at the read pointer; it holds the last popped word when empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
            if (count_d != '0) begin
                // New head is the word being written only when nothing else remains ahead of it.
                head_d = (push && (rd_ptr_d == wr_ptr_q)) ? din : mem_q[rd_ptr_d];
            end
        end
    end

    always_comb begin
        sticky_ov_d = (sticky_ov_q & ~i_sticky_clr) | (push & i_ov_flag);
        sticky_un_d = (sticky_un_q & ~i_sticky_clr) | (push & i_un_flag);
    end

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            head_q      <= '0;
            sticky_ov_q <= 1'b0;
            sticky_un_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            head_q      <= head_d;
            sticky_ov_q <= sticky_ov_d;
            sticky_un_q <= sticky_un_d;
        end
    end

    assign o_32_s      = head_q[31:0];
    assign o_un_flag   = head_q[32];
    assign o_ov_flag   = head_q[33];
    assign o_count     = count_q;
    assign o_sticky_ov = sticky_ov_q;
    assign o_sticky_un = sticky_un_q;

`ifdef FPU_RQ_EVENT_CNT_EN
    logic [CNT_W-1:0] ov_cnt_q, ov_cnt_d;
    logic [CNT_W-1:0] un_cnt_q, un_cnt_d;

    // Saturating increment; an increment coinciding with a clear yields 1.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                  input logic inc, input logic clr);
        logic [CNT_W-1:0] nxt;
        nxt = cur;
        if (inc) begin
            if (clr)       nxt = CNT_W'(1);
            else if (~&cur) nxt = cur + CNT_W'(1);
        end else if (clr) begin
            nxt = '0;
        end
        return nxt;
    endfunction

    always_comb begin
        ov_cnt_d = cnt_next(ov_cnt_q, push & i_ov_flag, i_sticky_clr);
        un_cnt_d = cnt_next(un_cnt_q, push & i_un_flag, i_sticky_clr);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ov_cnt_q <= '0;
            un_cnt_q <= '0;
        end else begin
            ov_cnt_q <= ov_cnt_d;
            un_cnt_q <= un_cnt_d;
        end
    end

    assign o_ov_cnt = ov_cnt_q;
    assign o_un_cnt = un_cnt_q;
`else
    assign o_ov_cnt = '0;
    assign o_un_cnt = '0;
`endif

endmodule

// File: tb/tb_fpu_result_queue.sv
// Self-checking bench for fpu_result_queue: directed scenarios plus random traffic
// compared each cycle against a queue-based reference model.
module tb_fpu_result_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_32_s;
    logic        i_ov_flag, i_un_flag;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_32_s;
    logic        o_ov_flag, o_un_flag;
    logic        i_flush, i_sticky_clr;
    logic        o_sticky_ov, o_sticky_un;
    logic [$clog2(DEPTH):0] o_count;
    logic [CNT_W-1:0] o_ov_cnt, o_un_cnt;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [33:0] mq[$];
    logic [33:0] m_last;
    bit          m_sov, m_sun;
    int          m_ovc, m_unc;

    fpu_result_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_32_s(i_32_s), .i_ov_flag(i_ov_flag), .i_un_flag(i_un_flag),
        .o_valid(o_valid), .i_ready(i_ready), .o_32_s(o_32_s),
        .o_ov_flag(o_ov_flag), .o_un_flag(o_un_flag), .i_flush(i_flush),
        .i_sticky_clr(i_sticky_clr), .o_sticky_ov(o_sticky_ov), .o_sticky_un(o_sticky_un),
        .o_count(o_count), .o_ov_cnt(o_ov_cnt), .o_un_cnt(o_un_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_last = '0;
        m_sov  = 1'b0;
        m_sun  = 1'b0;
        m_ovc  = 0;
        m_unc  = 0;
    endtask

    function automatic int cnt_upd(int cur, bit inc, bit clr);
`ifdef FPU_RQ_EVENT_CNT_EN
        if (inc) return clr ? 1 : ((cur < CNT_MAX) ? cur + 1 : CNT_MAX);
        return clr ? 0 : cur;
`else
        return 0;
`endif
    endfunction

    task automatic check_outputs(input string ph);
        logic [33:0] head;
        head = (mq.size() != 0) ? mq[0] : m_last;
        check({ph, ".ready"},  64'(o_ready), 64'((mq.size() < DEPTH) && !i_flush));
        check({ph, ".valid"},  64'(o_valid), 64'(mq.size() != 0));
        check({ph, ".data"},   64'({o_ov_flag, o_un_flag, o_32_s}), 64'(head));
        check({ph, ".count"},  64'(o_count), 64'(mq.size()));
        check({ph, ".s_ov"},   64'(o_sticky_ov), 64'(m_sov));
        check({ph, ".s_un"},   64'(o_sticky_un), 64'(m_sun));
        check({ph, ".ov_cnt"}, 64'(o_ov_cnt), 64'(m_ovc));
        check({ph, ".un_cnt"}, 64'(o_un_cnt), 64'(m_unc));
    endtask

    // One clock cycle: drive after the falling edge, check, advance model, cross the rising edge.
    task automatic cycle(input string ph, input bit v, input logic [31:0] d, input bit ov,
                         input bit un, input bit rdy, input bit fl, input bit clr);
        bit push, pop;
        i_valid = v; i_32_s = d; i_ov_flag = ov; i_un_flag = un;
        i_ready = rdy; i_flush = fl; i_sticky_clr = clr;
        #1;
        check_outputs(ph);
        push = v && !fl && (mq.size() < DEPTH);
        pop  = rdy && !fl && (mq.size() != 0);
        if (fl) begin
            if (mq.size() != 0) m_last = mq[0];
            mq.delete();
        end else begin
            if (pop)  m_last = mq.pop_front();
            if (push) mq.push_back({ov, un, d});
        end
        m_sov = (m_sov && !clr) || (push && ov);
        m_sun = (m_sun && !clr) || (push && un);
        m_ovc = cnt_upd(m_ovc, push && ov, clr);
        m_unc = cnt_upd(m_unc, push && un, clr);
        @(negedge i_clk);
    endtask

    task automatic idle(input string ph, input bit rdy);
        cycle(ph, 1'b0, 32'h0, 1'b0, 1'b0, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        i_rst_n = 1'b0; i_valid = 1'b0; i_32_s = '0; i_ov_flag = 1'b0; i_un_flag = 1'b0;
        i_ready = 1'b0; i_flush = 1'b0; i_sticky_clr = 1'b0;
        model_reset();
        @(negedge i_clk);
        check_outputs("rst");
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Single word through, one-cycle latency
        cycle("t1a", 1'b1, 32'h3F80_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle("t1b", 1'b1);
        idle("t1c", 1'b1);

        // Fill to full with consumer stalled, overfill refused, then drain in order
        for (int i = 1; i <= 5; i++) cycle("t2f", 1'b1, 32'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle("t2d", 1'b1);

        // Steady stream at occupancy 2 across several pointer wraps
        for (int i = 0; i < 2; i++) cycle("t3f", 1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3 * DEPTH + 2; i++)
            cycle("t3s", 1'b1, $urandom, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle("t3d", 1'b1);

        // Sticky: set beats clear, then clear alone
        cycle("t4a", 1'b1, 32'h7F80_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle("t4b", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle("t4c", 1'b1);
        for (int i = 0; i < 300; i++)
            cycle("t4n", 1'b1, $urandom, 1'b1, i[0], 1'b1, 1'b0, 1'b0);
        idle("t4e", 1'b1);

        // Flush with a concurrent push and pop
        for (int i = 0; i < 3; i++)
            cycle("t5f", 1'b1, $urandom, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("t5x", 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle("t5a", 1'b1);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++)
            cycle("t6f", 1'b1, $urandom, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        i_valid = 1'b0; i_flush = 1'b0;
        #2 i_rst_n = 1'b0;
        model_reset();
        #1 check_outputs("t6r");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        idle("t6a", 1'b1);

        // Random traffic
        for (int i = 0; i < 600; i++)
            cycle("rnd", ($urandom_range(0, 3) != 0), $urandom, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
